hdr_dispatcher: RTL and testbench

Ingress stage directly upstream of the packet processor (proc). It receives a packet header as a byte stream and assembles it into the HDR_MAX_LEN-byte header array that proc reads. It pulses proc's start, waits for proc to finish, then streams the buffered header bytes to the downstream egress logic. Only one packet is in flight at a time.

---
 rtl/hdr_dispatcher.sv | 181 ++++++++++++++++++
 tb/tb_hdr_dispatcher.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdr_dispatcher.sv
// Header dispatcher: collects a header byte stream into a fixed-size buffer,
// starts the packet processor, waits for it to finish, then streams the
// buffered bytes to egress. Only one packet is in flight at a time.
module hdr_dispatcher #(
    parameter int HDR_MAX_LEN = 64,
    parameter int LEN_W       = 7
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid_i,
    input  logic [7:0]                  in_data_i,
    input  logic                        in_last_i,
    output logic                        in_ready_o,
    output logic                        proc_start_o,
    output logic [HDR_MAX_LEN-1:0][7:0] proc_hdr_o,
    input  logic                        proc_ready_i,
    output logic                        out_valid_o,
    output logic [7:0]                  out_data_o,
    output logic                        out_last_o,
    input  logic                        out_ready_i,
    output logic [LEN_W-1:0]            hdr_len_o,
    output logic [31:0]                 pkt_cnt_o,
    output logic [31:0]                 trunc_cnt_o
);

    localparam int IDX_W = (HDR_MAX_LEN > 1) ? $clog2(HDR_MAX_LEN) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(HDR_MAX_LEN);

    typedef enum logic [2:0] {S_RECV, S_START, S_ARM, S_WAIT, S_SEND} state_t;

    state_t                        state_reg, state_next;
    logic                          in_ready_reg;
    logic                          proc_start_reg;
    logic [LEN_W-1:0]              wr_ptr_reg, wr_ptr_next;
    logic [LEN_W-1:0]              rd_ptr_reg, rd_ptr_next;
    logic [LEN_W-1:0]              rd_ptr_inc;
    logic                          trunc_reg, trunc_next;
    logic [LEN_W-1:0]              hdr_len_reg, hdr_len_next;
    logic                          out_valid_reg, out_valid_next;
    logic [7:0]                    out_data_reg, out_data_next;
    logic                          out_last_reg, out_last_next;
    logic [31:0]                   pkt_cnt_reg, pkt_cnt_next;
    logic [31:0]                   trunc_cnt_reg, trunc_cnt_next;
    logic                          buf_wr_en;
    logic                          buf_clr;
    logic [HDR_MAX_LEN-1:0][7:0]   buf_all;

    // Header buffer: one register per byte so proc can see the whole array.
    for (genvar gi = 0; gi < HDR_MAX_LEN; gi++) begin : g_byte
        logic [7:0] byte_reg;
        // Load on a write aimed at this slot; clear on reset and at packet end.
        always_ff @(posedge clk) begin
            if (!rst || buf_clr) begin
                byte_reg <= '0;
            end else if (buf_wr_en && (wr_ptr_reg[IDX_W-1:0] == IDX_W'(gi))) begin
                byte_reg <= in_data_i;
            end
        end
        assign buf_all[gi] = byte_reg;
    end

    // Next-state and datapath decisions for the packet lifecycle.
    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        trunc_next     = trunc_reg;
        hdr_len_next   = hdr_len_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_last_next  = out_last_reg;
        pkt_cnt_next   = pkt_cnt_reg;
        trunc_cnt_next = trunc_cnt_reg;
        buf_wr_en      = 1'b0;
        buf_clr        = 1'b0;
        rd_ptr_inc     = rd_ptr_reg + LEN_W'(1);

        case (state_reg)
            S_RECV: begin
                if (in_valid_i && in_ready_reg) begin
                    // Bytes beyond the buffer are dropped; the pointer saturates.
                    if (wr_ptr_reg < MAX_LEN) begin
                        buf_wr_en   = 1'b1;
                        wr_ptr_next = wr_ptr_reg + LEN_W'(1);
                    end else begin
                        trunc_next = 1'b1;
                    end
                    if (in_last_i) begin
                        state_next   = S_START;
                        hdr_len_next = (wr_ptr_reg < MAX_LEN) ? wr_ptr_reg + LEN_W'(1) : MAX_LEN;
                    end
                end
            end
            S_START: begin
                state_next = S_ARM;
            end
            S_ARM: begin
                // A ready still high from the previous packet must be seen low first.
                if (!proc_ready_i) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (proc_ready_i) begin
                    state_next     = S_SEND;
                    rd_ptr_next    = '0;
                    out_valid_next = 1'b1;
                    out_data_next  = buf_all[0];
                    out_last_next  = (hdr_len_reg == LEN_W'(1));
                end
            end
            S_SEND: begin
                if (out_valid_reg && out_ready_i) begin
                    if (out_last_reg) begin
                        state_next     = S_RECV;
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        out_data_next  = '0;
                        pkt_cnt_next   = pkt_cnt_reg + 32'd1;
                        if (trunc_reg) begin
                            trunc_cnt_next = trunc_cnt_reg + 32'd1;
                        end
                        buf_clr     = 1'b1;
                        wr_ptr_next = '0;
                        rd_ptr_next = '0;
                        trunc_next  = 1'b0;
                    end else begin
                        rd_ptr_next   = rd_ptr_inc;
                        out_data_next = buf_all[rd_ptr_inc[IDX_W-1:0]];
                        out_last_next = ((rd_ptr_inc + LEN_W'(1)) == hdr_len_reg);
                    end
                end
            end
            default: begin
                state_next = S_RECV;
            end
        endcase
    end

    // State and output registers; ready and start are derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= S_RECV;
            in_ready_reg   <= 1'b0;
            proc_start_reg <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            trunc_reg      <= 1'b0;
            hdr_len_reg    <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            out_last_reg   <= 1'b0;
            pkt_cnt_reg    <= '0;
            trunc_cnt_reg  <= '0;
        end else begin
            state_reg      <= state_next;
            in_ready_reg   <= (state_next == S_RECV);
            proc_start_reg <= (state_next == S_START);
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            trunc_reg      <= trunc_next;
            hdr_len_reg    <= hdr_len_next;
            out_valid_reg  <= out_valid_next;
            out_data_reg   <= out_data_next;
            out_last_reg   <= out_last_next;
            pkt_cnt_reg    <= pkt_cnt_next;
            trunc_cnt_reg  <= trunc_cnt_next;
        end
    end

    assign in_ready_o   = in_ready_reg;
    assign proc_start_o = proc_start_reg;
    assign proc_hdr_o   = buf_all;
    assign out_valid_o  = out_valid_reg;
    assign out_data_o   = out_data_reg;
    assign out_last_o   = out_last_reg;
    assign hdr_len_o    = hdr_len_reg;
    assign pkt_cnt_o    = pkt_cnt_reg;
    assign trunc_cnt_o  = trunc_cnt_reg;

endmodule

// File: tb/tb_hdr_dispatcher.sv
// Bench for hdr_dispatcher: table of packets plus hand-written reset and
// back-to-back sequences; output bytes are checked against a scoreboard queue.
module tb_hdr_dispatcher;

    localparam int HML = 64;
    localparam int LW  = 7;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                in_valid = 1'b0;
    logic [7:0]          in_data = '0;
    logic                in_last = 1'b0;
    logic                in_ready;
    logic                proc_start;
    logic [HML-1:0][7:0] proc_hdr;
    logic                proc_ready = 1'b1;
    logic                out_valid;
    logic [7:0]          out_data;
    logic                out_last;
    logic                out_ready = 1'b1;
    logic [LW-1:0]       hdr_len;
    logic [31:0]         pkt_cnt;
    logic [31:0]         trunc_cnt;

    hdr_dispatcher #(.HDR_MAX_LEN(HML), .LEN_W(LW)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .in_ready_o   (in_ready),
        .proc_start_o (proc_start),
        .proc_hdr_o   (proc_hdr),
        .proc_ready_i (proc_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_last_o   (out_last),
        .out_ready_i  (out_ready),
        .hdr_len_o    (hdr_len),
        .pkt_cnt_o    (pkt_cnt),
        .trunc_cnt_o  (trunc_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         len;
        logic [7:0] base;
        int         rmode;
        int         exp_len;
        int         exp_tr;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } beat_t;

    vec_t  tbl [5];
    beat_t exp_q [$];

    int    errors = 0;
    int    checks = 0;
    int    rx_count = 0;
    int    ready_mode = 0;
    int    proc_delay = 10;
    bit    mon_en = 1'b1;
    time   first_valid_time = 0;
    time   proc_rise_time = 0;
    int    exp_pkt = 0;
    int    exp_trunc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_hdr(input string nm, input logic [HML*8-1:0] act, input logic [HML*8-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [HML*8-1:0] mk_hdr(input int len, input logic [7:0] base);
        logic [HML-1:0][7:0] v;
        v = '0;
        for (int i = 0; i < len && i < HML; i++) v[i] = base + 8'(i);
        return v;
    endfunction

    // Present one input beat and hold it until accepted; st returns stall cycles.
    task automatic drive_beat(input logic [7:0] d, input logic l, output int st);
        st = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        @(negedge clk);
        while (!in_ready && st < 200) begin
            @(negedge clk);
            st++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: byte 0x%0h never accepted", d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (t >= 3000) begin
            errors++;
            $display("FAIL %s: send not finished, %0d bytes outstanding", nm, exp_q.size());
        end
    endtask

    // Proc model: ready stays stale for 2 cycles after start, drops, then rises.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (proc_start) begin
                repeat (2) @(posedge clk);
                #1 proc_ready = 1'b0;
                repeat (proc_delay) @(posedge clk);
                #1 proc_ready = 1'b1;
                proc_rise_time = $time;
            end
        end
    end

    // Egress back-pressure: mode 0 always ready, mode 1 repeats 1,0,0.
    initial begin
        int phase = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 1) begin
                out_ready = (phase == 0);
                phase = (phase + 1) % 3;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Output monitor: scoreboard compare on handshake, hold check while stalled.
    initial begin
        bit         stall_pending = 1'b0;
        logic [7:0] held_data = '0;
        logic       held_last = 1'b0;
        beat_t      e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (stall_pending)
                    chk("stall_hold", {23'd0, out_valid, out_last, out_data},
                        {23'd0, 1'b1, held_last, held_data});
                stall_pending = out_valid && !out_ready;
                held_data = out_data;
                held_last = out_last;
                if (out_valid && first_valid_time == 0) first_valid_time = $time;
                if (out_valid && out_ready) begin
                    rx_count++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got data 0x%0h last %0b, want nothing", out_data, out_last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_beat", {23'd0, out_last, out_data}, {23'd0, e.last, e.data});
                    end
                end
            end else begin
                stall_pending = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int stall_tot;
        int rx0;
        int t;

        tbl[0] = '{len: 14, base: 8'h00, rmode: 0, exp_len: 14, exp_tr: 0};
        tbl[1] = '{len: 70, base: 8'h40, rmode: 0, exp_len: 64, exp_tr: 1};
        tbl[2] = '{len: 64, base: 8'h80, rmode: 1, exp_len: 64, exp_tr: 0};
        tbl[3] = '{len: 1,  base: 8'h5A, rmode: 0, exp_len: 1,  exp_tr: 0};
        tbl[4] = '{len: 20, base: 8'hC0, rmode: 1, exp_len: 20, exp_tr: 0};

        // Reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_proc_start", proc_start, 0);
        chk("rst_out", {out_valid, out_last, out_data}, 0);
        chk("rst_hdr_len", hdr_len, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_trunc_cnt", trunc_cnt, 0);
        chk_hdr("rst_hdr", proc_hdr, '0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", in_ready, 1);

        // Table-driven packets
        for (int k = 0; k < 5; k++) begin
            ready_mode = tbl[k].rmode;
            first_valid_time = 0;
            stall_tot = 0;
            for (int i = 0; i < tbl[k].exp_len; i++)
                exp_q.push_back('{data: tbl[k].base + 8'(i), last: (i == tbl[k].exp_len - 1)});
            for (int i = 0; i < tbl[k].len; i++) begin
                drive_beat(tbl[k].base + 8'(i), (i == tbl[k].len - 1), st);
                stall_tot += st;
            end
            exp_pkt++;
            exp_trunc += tbl[k].exp_tr;
            chk("in_ready_stalls", stall_tot, 0);
            chk("start_pulse", proc_start, 1);
            chk("in_ready_low", in_ready, 0);
            chk("hdr_len", hdr_len, tbl[k].exp_len);
            chk_hdr("hdr_buf", proc_hdr, mk_hdr(tbl[k].len, tbl[k].base));
            @(posedge clk);
            #1;
            chk("start_one_cycle", proc_start, 0);
            wait_done("pkt_done");
            chk("no_out_before_proc", first_valid_time > proc_rise_time, 1);
            chk("pkt_cnt", pkt_cnt, exp_pkt);
            chk("trunc_cnt", trunc_cnt, exp_trunc);
            chk_hdr("hdr_cleared", proc_hdr, '0);
            chk("in_ready_back", in_ready, 1);
        end

        // Reset in the middle of sending a 14-byte packet
        ready_mode = 0;
        for (int i = 0; i < 14; i++)
            exp_q.push_back('{data: 8'h10 + 8'(i), last: (i == 13)});
        for (int i = 0; i < 14; i++) drive_beat(8'h10 + 8'(i), (i == 13), st);
        rx0 = rx_count;
        t = 0;
        while (rx_count < rx0 + 5 && t < 500) begin
            @(posedge clk);
            #2;
            t++;
        end
        chk("mid_send_bytes", rx_count - rx0, 5);
        rst = 1'b0;
        mon_en = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_in_ready", in_ready, 0);
        chk("mrst_pkt_cnt", pkt_cnt, 0);
        chk("mrst_trunc_cnt", trunc_cnt, 0);
        chk_hdr("mrst_hdr", proc_hdr, '0);
        rst = 1'b1;
        exp_q.delete();
        exp_pkt = 0;
        exp_trunc = 0;
        @(posedge clk);
        #1;
        chk("mrst_rel_in_ready", in_ready, 1);
        mon_en = 1'b1;

        // Two back-to-back single-byte packets with valid held high
        exp_q.push_back('{data: 8'hAA, last: 1'b1});
        exp_q.push_back('{data: 8'hBB, last: 1'b1});
        drive_beat(8'hAA, 1'b1, st);
        exp_pkt++;
        drive_beat(8'hBB, 1'b1, st);
        chk("b2b_held_off", st > 5, 1);
        chk("b2b_first_done", pkt_cnt, exp_pkt);
        exp_pkt++;
        wait_done("b2b_done");
        chk("b2b_pkt_cnt", pkt_cnt, exp_pkt);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
